// File: rtl/dct_transpose_buffer.sv
// Ping-pong 16x16 transpose store between the row and column 1-D DCT passes.
// Rows are written whole; each column is read by picking one element position from every row.
module dct_transpose_buffer #(
  parameter int N = 16,
  parameter int W = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           out_last
);

  // state      | meaning
  // BANK_EMPTY | bank owned by the writer, accepting rows
  // BANK_FULL  | bank holds a complete block, owned by the reader
  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_t;

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  bank_t                     bank_st  [2];
  bank_t                     bank_nxt [2];
  logic                      wr_bank;
  logic                      rd_bank;
  logic [CW-1:0]             row_cnt;
  logic [CW-1:0]             col_cnt;
  logic [N-1:0][W-1:0]       mem [2][N];
  logic                      wr_fire;
  logic                      rd_fire;
  logic                      wr_done;
  logic                      rd_done;

  assign in_ready  = (bank_st[wr_bank] == BANK_EMPTY);
  assign out_valid = (bank_st[rd_bank] == BANK_FULL);
  assign out_last  = out_valid && (col_cnt == CNT_LAST);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_done   = wr_fire && (row_cnt == CNT_LAST);
  assign rd_done   = rd_fire && (col_cnt == CNT_LAST);

  // A write completion and a read completion never target the same bank:
  // one needs it EMPTY, the other FULL.
  always_comb begin
    bank_nxt = bank_st;
    if (wr_done) bank_nxt[wr_bank] = BANK_FULL;
    if (rd_done) bank_nxt[rd_bank] = BANK_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      row_cnt    <= '0;
      col_cnt    <= '0;
    end else begin
      bank_st <= bank_nxt;
      if (wr_fire) begin
        row_cnt <= wr_done ? '0 : row_cnt + CW'(1);
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        col_cnt <= rd_done ? '0 : col_cnt + CW'(1);
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  // Storage is intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][row_cnt] <= in_data;
  end

  for (genvar r = 0; r < N; r++) begin : g_col
    assign out_data[r*W +: W] = mem[rd_bank][r][col_cnt];
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed and scoreboard bench for the ping-pong transpose buffer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dct_transpose_buffer;
  localparam int N = 16;
  localparam int W = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic           out_last;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0]   blk [N][N];
  logic [N*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  dct_transpose_buffer #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  function automatic logic [N*W-1:0] row_of(int i);
    logic [N*W-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = blk[i][k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] col_of(int c);
    logic [N*W-1:0] v = '0;
    for (int r = 0; r < N; r++) v[r*W +: W] = blk[r][c];
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++;
    if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b exp 0", out_last); end
  endtask

  task automatic test_single_block();
    logic [N*W-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) blk[i][k] = W'(16*i + k);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++; $display("FAIL t1_fill row=%0d got valid=%b ready=%b exp 0/1", i, out_valid, in_ready);
      end
      in_valid = 1'b1; in_data = row_of(i);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) e[r*W +: W] = W'(16*r + c);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL t1_valid c=%0d got %b exp 1", c, out_valid); end
      vectors++;
      if (out_data !== e) begin miscompares++; $display("FAIL t1_data c=%0d got %h exp %h", c, out_data, e); end
      vectors++;
      if (out_last !== (c == N-1)) begin miscompares++; $display("FAIL t1_last c=%0d got %b exp %b", c, out_last, (c == N-1)); end
      @(negedge clk);
    end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL t1_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] e;
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 80 && n < 3*N; t++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (n == 0) begin
          vectors++;
          if (t != N) begin miscompares++; $display("FAIL t2_first_cycle got %0d exp %0d", t, N); end
        end
        for (int r = 0; r < N; r++) e[r*W +: W] = W'((n/N)*256 + 16*r + n%N);
        vectors++;
        if (out_data !== e || out_last !== (n%N == N-1)) begin
          miscompares++; $display("FAIL t2_col n=%0d got %h/%b exp %h/%b", n, out_data, out_last, e, (n%N == N-1));
        end
        n++;
      end else if (n > 0) begin
        vectors++; miscompares++; $display("FAIL t2_bubble n=%0d got valid=0 exp 1", n);
      end
      if (t < 3*N) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL t2_in_ready t=%0d got %b exp 1", t, in_ready); end
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = W'((t/N)*256 + 16*(t%N) + k);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (n != 3*N) begin miscompares++; $display("FAIL t2_count got %0d exp %0d", n, 3*N); end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] e;
    logic [N*W-1:0] held = '0;
    logic           have_held = 1'b0;
    int acc = 0;
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== (acc < 2*N)) begin
        miscompares++; $display("FAIL t3_in_ready acc=%0d got %b exp %b", acc, in_ready, (acc < 2*N));
      end
      if (out_valid === 1'b1) begin
        if (!have_held) begin held = out_data; have_held = 1'b1; end
        vectors++;
        if (out_data !== held || out_last !== 1'b0) begin
          miscompares++; $display("FAIL t3_hold t=%0d got %h exp %h", t, out_data, held);
        end
      end
      in_valid = 1'b1;
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'((acc/N)*300 + 16*(acc%N) + k);
      if (in_ready === 1'b1) acc++;
    end
    vectors++;
    if (acc != 2*N) begin miscompares++; $display("FAIL t3_accepted got %0d exp %0d", acc, 2*N); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 2*N; n++) begin
      for (int r = 0; r < N; r++) e[r*W +: W] = W'((n/N)*300 + 16*r + n%N);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== e || out_last !== (n%N == N-1)) begin
        miscompares++; $display("FAIL t3_drain n=%0d got %b/%h exp 1/%h", n, out_valid, out_data, e);
      end
      @(negedge clk);
    end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL t3_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    logic [N*W-1:0] e;
    int sent = 0;
    int recv = 0;
    do_reset();
    exp_q.delete();
    for (int t = 0; t < 20000 && recv < 20*N; t++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL t4_extra recv=%0d got %h exp none", recv, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e || out_last !== (recv%N == N-1)) begin
            miscompares++; $display("FAIL t4_col recv=%0d got %h/%b exp %h/%b", recv, out_data, out_last, e, (recv%N == N-1));
          end
        end
        recv++;
      end
      if (sent < 20*N && $urandom_range(0, 1) == 1) begin
        for (int k = 0; k < N; k++) blk[sent%N][k] = W'($urandom);
        in_valid = 1'b1; in_data = row_of(sent%N);
        if (in_ready === 1'b1) begin
          sent++;
          if (sent%N == 0) for (int c = 0; c < N; c++) exp_q.push_back(col_of(c));
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (recv != 20*N || sent != 20*N || exp_q.size() != 0) begin
      miscompares++; $display("FAIL t4_count got sent=%0d recv=%0d left=%0d exp %0d/%0d/0", sent, recv, exp_q.size(), 20*N, 20*N);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = {N{11'h2AA}};
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL t5_rst_rows got valid=%b ready=%b exp 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) blk[i][k] = W'(500 + 16*i + k);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = row_of(i);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== col_of(c)) begin
        miscompares++; $display("FAIL t5_partial c=%0d got %b/%h exp 1/%h", c, out_valid, out_data, col_of(c));
      end
      @(negedge clk);
    end
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL t5_rst_drain got valid=%b ready=%b exp 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) blk[i][k] = W'($urandom);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = row_of(i);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== col_of(c) || out_last !== (c == N-1)) begin
        miscompares++; $display("FAIL t5_after c=%0d got %b/%h/%b exp 1/%h/%b", c, out_valid, out_data, out_last, col_of(c), (c == N-1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_signed();
    logic [N*W-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) blk[i][k] = ((i + k) % 2 == 1) ? 11'h3FF : 11'h400;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = row_of(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) e[r*W +: W] = ((r + c) % 2 == 1) ? 11'h3FF : 11'h400;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        miscompares++; $display("FAIL t6_signed c=%0d got %b/%h exp 1/%h", c, out_valid, out_data, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
